alu_exec_unit: RTL and testbench

Execution-stage ALU that consumes the 5-bit `aluControl` code produced by the instruction control unit and returns the computed result. Operands and code are accepted over a valid/ready handshake. Single-cycle operations complete in one cycle. Multiply, divide and remainder run iteratively over XLEN cycles. The result is held until the writeback stage accepts it.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_exec_unit_muldiv.sv | 85 ++++++++
 rtl/alu_exec_unit.sv | 103 ++++++++++
 tb/tb_alu_exec_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU operation codes, FSM state type and iterative-op classifier.
// ALU_EXEC_DIV_EN adds DIVU/REMU to the iterative set; otherwise those codes are illegal.
package alu_pkg;

  localparam logic [4:0] ALU_ADD   = 5'b00000;
  localparam logic [4:0] ALU_SUB   = 5'b00001;
  localparam logic [4:0] ALU_AND   = 5'b00010;
  localparam logic [4:0] ALU_OR    = 5'b00011;
  localparam logic [4:0] ALU_XOR   = 5'b00100;
  localparam logic [4:0] ALU_SLL   = 5'b00101;
  localparam logic [4:0] ALU_SRL   = 5'b00110;
  localparam logic [4:0] ALU_SRA   = 5'b00111;
  localparam logic [4:0] ALU_SLT   = 5'b01000;
  localparam logic [4:0] ALU_SLTU  = 5'b01001;
  localparam logic [4:0] ALU_MUL   = 5'b10101;
  localparam logic [4:0] ALU_MULHU = 5'b10110;
  localparam logic [4:0] ALU_DIVU  = 5'b11010;
  localparam logic [4:0] ALU_REMU  = 5'b11100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

  function automatic logic is_iterative(input logic [4:0] code);
    logic w_it;
    w_it = (code == ALU_MUL) || (code == ALU_MULHU);
`ifdef ALU_EXEC_DIV_EN
    w_it = w_it || (code == ALU_DIVU) || (code == ALU_REMU);
`endif
    return w_it;
  endfunction

endpackage

// File: rtl/alu_exec_unit_muldiv.sv
// Iterative shift-add multiplier and (with ALU_EXEC_DIV_EN) restoring divider; XLEN
// iterations after i_start, o_done flags the final-iteration cycle with o_result valid.
module alu_iter_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [4:0]      i_code,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);
  import alu_pkg::*;

  localparam int CW = $clog2(XLEN);

  logic              r_busy;
  logic [CW-1:0]     r_cnt;
  logic [4:0]        r_code;
  logic [XLEN-1:0]   r_b;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_nxt;
  logic [2*XLEN-1:0] w_acc_nxt;

  // Low half starts as the multiplier and is consumed one bit per shift.
  assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_b};
  assign w_mul_nxt = r_acc[0] ? {w_mul_sum, r_acc[XLEN-1:1]} : {1'b0, r_acc[2*XLEN-1:1]};

`ifdef ALU_EXEC_DIV_EN
  logic [XLEN-1:0] r_a;
  logic [XLEN:0]   w_div_trial;
  logic [2*XLEN-1:0] w_div_nxt;
  logic            w_is_div;

  // High half holds the partial remainder, low half shifts dividend out and quotient in.
  assign w_div_trial = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_b};
  assign w_div_nxt   = w_div_trial[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                         : {w_div_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
  assign w_is_div    = (r_code == ALU_DIVU) || (r_code == ALU_REMU);
  assign w_acc_nxt   = w_is_div ? w_div_nxt : w_mul_nxt;
`else
  assign w_acc_nxt   = w_mul_nxt;
`endif

  always_comb begin
    o_result = w_acc_nxt[XLEN-1:0];
    if (r_code == ALU_MULHU) o_result = w_acc_nxt[2*XLEN-1:XLEN];
`ifdef ALU_EXEC_DIV_EN
    if (r_code == ALU_DIVU) o_result = (r_b == '0) ? '1 : w_acc_nxt[XLEN-1:0];
    if (r_code == ALU_REMU) o_result = (r_b == '0) ? r_a : w_acc_nxt[2*XLEN-1:XLEN];
`endif
  end

  assign o_done = r_busy && (r_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_code <= '0;
      r_b    <= '0;
      r_acc  <= '0;
`ifdef ALU_EXEC_DIV_EN
      r_a    <= '0;
`endif
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= CW'(XLEN-1);
      r_code <= i_code;
      r_b    <= i_b;
      r_acc  <= {{XLEN{1'b0}}, i_a};
`ifdef ALU_EXEC_DIV_EN
      r_a    <= i_a;
`endif
    end else if (r_busy) begin
      r_acc <= w_acc_nxt;
      if (r_cnt == '0) r_busy <= 1'b0;
      else             r_cnt  <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execution ALU: single-cycle ops done 1 cycle after accept, MUL/MULHU (and DIVU/REMU with
// ALU_EXEC_DIV_EN) XLEN+1; one op in flight, result held until out_ready, in_ready only in IDLE.
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      aluControl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);
  import alu_pkg::*;

  localparam int SHW = $clog2(XLEN);

  alu_state_t      r_state;
  logic [XLEN-1:0] r_result;
  logic            r_zero;
  logic            r_illegal;
  logic [XLEN-1:0] w_sc_res;
  logic            w_sc_ill;
  logic [SHW-1:0]  w_shamt;
  logic            w_start;
  logic            w_md_done;
  logic [XLEN-1:0] w_md_res;

  assign w_shamt = op_b[SHW-1:0];

  always_comb begin
    w_sc_res = '0;
    w_sc_ill = 1'b0;
    case (aluControl)
      ALU_ADD:  w_sc_res = op_a + op_b;
      ALU_SUB:  w_sc_res = op_a - op_b;
      ALU_AND:  w_sc_res = op_a & op_b;
      ALU_OR:   w_sc_res = op_a | op_b;
      ALU_XOR:  w_sc_res = op_a ^ op_b;
      ALU_SLL:  w_sc_res = op_a << w_shamt;
      ALU_SRL:  w_sc_res = op_a >> w_shamt;
      ALU_SRA:  w_sc_res = $signed(op_a) >>> w_shamt;
      ALU_SLT:  w_sc_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: w_sc_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      default:  w_sc_ill = 1'b1;
    endcase
  end

  assign w_start = (r_state == ST_IDLE) && in_valid && is_iterative(aluControl);

  alu_iter_muldiv #(.XLEN(XLEN)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_start),
    .i_code   (aluControl),
    .i_a      (op_a),
    .i_b      (op_b),
    .o_done   (w_md_done),
    .o_result (w_md_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_result  <= '0;
      r_zero    <= 1'b1;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (in_valid) begin
          if (is_iterative(aluControl)) begin
            r_state <= ST_CALC;
          end else begin
            r_result  <= w_sc_res;
            r_zero    <= (w_sc_res == '0);
            r_illegal <= w_sc_ill;
            r_state   <= ST_DONE;
          end
        end
        ST_CALC: if (w_md_done) begin
          r_result  <= w_md_res;
          r_zero    <= (w_md_res == '0);
          r_illegal <= 1'b0;
          r_state   <= ST_DONE;
        end
        ST_DONE: if (out_ready) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit at XLEN=32; divider expectations follow ALU_EXEC_DIV_EN.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  aluControl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int n_asserts = 0;
  int n_fail    = 0;
  int lat;
  logic [31:0] held;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .aluControl (aluControl),
    .op_a       (op_a),
    .op_b       (op_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one op, returns edges from acceptance (inclusive) until out_valid is seen.
  task automatic issue(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                       input bit pulse, output int lat_o);
    @(negedge clk);
    chk("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
    aluControl = code; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat_o = 1;
    while (!out_valid && lat_o < 100) begin
      if (pulse) begin
        chk("in_ready_during_calc", {31'd0, in_ready}, 32'd0);
        aluControl = 5'b00000; op_a = 32'h1234_5678; op_b = 32'h1;
        in_valid = (lat_o % 3 == 0);
      end
      @(posedge clk); #1;
      lat_o++;
    end
    in_valid = 1'b0;
  endtask

  task automatic consume;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("in_ready_after_handshake", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic check_res(input string tag, input logic [31:0] exp_res, input logic exp_ill,
                           input int exp_lat, input int got_lat);
    chk({tag, "_latency"}, got_lat, exp_lat);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_zero"}, {31'd0, zero}, {31'd0, (exp_res == 32'd0)});
    chk({tag, "_illegal"}, {31'd0, illegal}, {31'd0, exp_ill});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    aluControl = '0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd1);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // ADD wrap with out_ready held high the whole time
    out_ready = 1'b1;
    issue(5'b00000, 32'hFFFF_FFFF, 32'h1, 1'b0, lat);
    check_res("add_wrap", 32'h0, 1'b0, 1, lat);
    @(posedge clk); #1;
    chk("add_handshake_in_ready", {31'd0, in_ready}, 32'd1);
    chk("add_handshake_out_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    issue(5'b00111, 32'h8000_0000, 32'h24, 1'b0, lat);
    check_res("sra", 32'hF800_0000, 1'b0, 1, lat);
    consume();
    issue(5'b01000, 32'hFFFF_FFFF, 32'h1, 1'b0, lat);
    check_res("slt", 32'h1, 1'b0, 1, lat);
    consume();
    issue(5'b01001, 32'hFFFF_FFFF, 32'h1, 1'b0, lat);
    check_res("sltu", 32'h0, 1'b0, 1, lat);
    consume();
    issue(5'b00001, 32'h5, 32'h7, 1'b0, lat);
    check_res("sub", 32'hFFFF_FFFE, 1'b0, 1, lat);
    consume();
    issue(5'b00101, 32'h0000_0003, 32'hFFFF_FFE4, 1'b0, lat);
    check_res("sll", 32'h0000_0030, 1'b0, 1, lat);
    consume();
    issue(5'b00110, 32'h8000_0000, 32'h1F, 1'b0, lat);
    check_res("srl", 32'h0000_0001, 1'b0, 1, lat);
    consume();
    issue(5'b00100, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, lat);
    check_res("xor", 32'h0FF0_0FF0, 1'b0, 1, lat);
    consume();
    issue(5'b01111, 32'h1234, 32'h5678, 1'b0, lat);
    check_res("illegal_code", 32'h0, 1'b1, 1, lat);
    consume();

    // MULHU with in_valid pulses during CALC that must be ignored
    issue(5'b10110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat);
    check_res("mulhu", 32'hFFFF_FFFE, 1'b0, 33, lat);
    consume();
    chk("no_extra_op_out_valid", {31'd0, out_valid}, 32'd0);
    issue(5'b10101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
    check_res("mul", 32'h0000_0001, 1'b0, 33, lat);
    consume();
    issue(5'b10101, 32'd12345, 32'd6789, 1'b0, lat);
    check_res("mul_small", 32'd83810205, 1'b0, 33, lat);
    consume();

`ifdef ALU_EXEC_DIV_EN
    issue(5'b11010, 32'd100, 32'd7, 1'b0, lat);
    check_res("divu", 32'd14, 1'b0, 33, lat);
    consume();
    issue(5'b11100, 32'd100, 32'd7, 1'b0, lat);
    check_res("remu", 32'd2, 1'b0, 33, lat);
    consume();
    issue(5'b11010, 32'hDEAD_BEEF, 32'd0, 1'b0, lat);
    check_res("divu_by0", 32'hFFFF_FFFF, 1'b0, 33, lat);
    consume();
    issue(5'b11100, 32'd9, 32'd0, 1'b0, lat);
    check_res("remu_by0", 32'd9, 1'b0, 33, lat);
    consume();
`else
    issue(5'b11010, 32'd100, 32'd7, 1'b0, lat);
    check_res("divu_disabled", 32'h0, 1'b1, 1, lat);
    consume();
    issue(5'b11100, 32'd100, 32'd7, 1'b0, lat);
    check_res("remu_disabled", 32'h0, 1'b1, 1, lat);
    consume();
`endif

    // Backpressure: result held with out_ready low for 10 cycles
    issue(5'b00010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, lat);
    check_res("and", 32'h00F0_00F0, 1'b0, 1, lat);
    held = 32'h00F0_00F0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_result", result, held);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    consume();

    // Reset at iteration 10 of a MUL abandons it
    @(negedge clk);
    aluControl = 5'b10101; op_a = 32'd3; op_b = 32'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("pre_rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_result", result, 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("abandoned_no_output", {31'd0, out_valid}, 32'd0);
    issue(5'b00000, 32'd2, 32'd3, 1'b0, lat);
    check_res("add_after_rst", 32'd5, 1'b0, 1, lat);
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
